// File: rtl/matmul_pkg.sv
// Shared types and derivations for the matmul sequencer: state encoding,
// dimension/counter width helpers and the operand-dimension clamp.
package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FEED,
    ST_DRAIN,
    ST_WRITE,
    ST_DONE
  } seq_state_e;

  function automatic int unsigned calc_max_dim(input int unsigned bus_w, input int unsigned data_w);
    return (bus_w / data_w < 1) ? 1 : bus_w / data_w;
  endfunction

  // Feed counter spans 3*MAX_DIM-2 skew steps; keep at least one bit.
  function automatic int unsigned calc_cnt_w(input int unsigned max_dim);
    int unsigned steps;
    steps = 3 * max_dim - 2;
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

  function automatic int unsigned calc_addr_w(input int unsigned max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

  function automatic logic [1:0] clamp_dim(input logic [1:0] d, input int unsigned max_dim);
    if ({30'd0, d} > max_dim - 1) return 2'(max_dim - 1);
    return d;
  endfunction

  localparam int unsigned MAX_DIM_DEF = calc_max_dim(16, 8);
  localparam int unsigned CNT_W_DEF   = calc_cnt_w(MAX_DIM_DEF);
  localparam int unsigned ADDR_W_DEF  = calc_addr_w(MAX_DIM_DEF);

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control/status bundle between the register file (master) and the
// matmul sequencer (slave).
interface matmul_sequencer_if #(
  parameter int unsigned CNT_W  = 2,
  parameter int unsigned ADDR_W = 1
);
  logic              start_i;
  logic              abort_i;
  logic [1:0]        dim_n_i;
  logic [1:0]        dim_k_i;
  logic [1:0]        dim_m_i;
  logic              mode_bias_i;
  logic              start_bit_o;
  logic [CNT_W-1:0]  counter_o;
  logic              reload_op_o;
  logic              pe_clear_o;
  logic              res_we_o;
  logic [ADDR_W-1:0] res_addr_o;
  logic              op_wr_block_o;
  logic              busy_o;
  logic              done_o;
  logic              start_ignored_o;
  logic [1:0]        k_o;
  logic [1:0]        m_o;
  logic [1:0]        n_o;

  modport slave (
    input  start_i, abort_i, dim_n_i, dim_k_i, dim_m_i, mode_bias_i,
    output start_bit_o, counter_o, reload_op_o, pe_clear_o, res_we_o, res_addr_o,
           op_wr_block_o, busy_o, done_o, start_ignored_o, k_o, m_o, n_o
  );

  modport master (
    output start_i, abort_i, dim_n_i, dim_k_i, dim_m_i, mode_bias_i,
    input  start_bit_o, counter_o, reload_op_o, pe_clear_o, res_we_o, res_addr_o,
           op_wr_block_o, busy_o, done_o, start_ignored_o, k_o, m_o, n_o
  );
endinterface

// File: rtl/matmul_sequencer_seq_counter.sv
// Loadable up-counter with terminal-count flag; wraps to zero when it
// advances past the terminal value.
module seq_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] count_o,
  output logic         tc_o
);
  logic [W-1:0] count_q, count_d;

  assign tc_o    = (count_q == term_i);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (load_i) count_d = load_val_i;
    else if (en_i)   count_d = tc_o ? '0 : count_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end
endmodule

// File: rtl/matmul_sequencer.sv
// Sequences one matmul: CLEAR -> FEED -> DRAIN -> WRITE -> DONE.
// Optional MATMUL_SEQ_ACCUM_EN: mode_bias_i latched at start suppresses pe_clear_o.
module matmul_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned PIPE_LAT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  matmul_sequencer_if.slave bus
);
  localparam int unsigned MAX_DIM = calc_max_dim(BUS_WIDTH, DATA_WIDTH);
  localparam int unsigned CNT_W   = calc_cnt_w(MAX_DIM);
  localparam int unsigned ADDR_W  = calc_addr_w(MAX_DIM);
  localparam int unsigned DRN_W   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(3 * MAX_DIM - 3);
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'((PIPE_LAT > 0) ? PIPE_LAT - 1 : 0);

  seq_state_e        state_q, state_d;
  logic [1:0]        n_q, k_q, m_q;
  logic              bias_q;
  logic [CNT_W-1:0]  feed_cnt;
  logic [DRN_W-1:0]  drain_cnt;
  logic [ADDR_W-1:0] wr_cnt;
  logic              feed_tc, drain_tc, wr_tc;
  logic              abort_hit, cnt_clr, load_all, accept;

  assign accept    = (state_q == ST_IDLE) && bus.start_i;
  assign abort_hit = bus.abort_i && (state_q != ST_IDLE);
  assign cnt_clr   = abort_hit || (state_q == ST_IDLE);
  assign load_all  = (state_q == ST_CLEAR);

  seq_counter #(.W(CNT_W)) u_feed (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .load_i(load_all), .load_val_i('0),
    .en_i(state_q == ST_FEED), .term_i(FEED_LAST), .count_o(feed_cnt), .tc_o(feed_tc)
  );

  seq_counter #(.W(DRN_W)) u_drain (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .load_i(load_all), .load_val_i('0),
    .en_i(state_q == ST_DRAIN), .term_i(DRAIN_LAST), .count_o(drain_cnt), .tc_o(drain_tc)
  );

  seq_counter #(.W(ADDR_W)) u_write (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr), .load_i(load_all), .load_val_i('0),
    .en_i(state_q == ST_WRITE), .term_i(ADDR_W'(n_q)), .count_o(wr_cnt), .tc_o(wr_tc)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      n_q <= '0;
      k_q <= '0;
      m_q <= '0;
    end else if (accept) begin
      n_q <= clamp_dim(bus.dim_n_i, MAX_DIM);
      k_q <= clamp_dim(bus.dim_k_i, MAX_DIM);
      m_q <= clamp_dim(bus.dim_m_i, MAX_DIM);
    end
  end

`ifdef MATMUL_SEQ_ACCUM_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       bias_q <= 1'b0;
    else if (accept) bias_q <= bus.mode_bias_i;
  end
`else
  assign bias_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.start_i) state_d = ST_CLEAR;
      ST_CLEAR: state_d = ST_FEED;
      ST_FEED:  if (feed_tc) state_d = (PIPE_LAT == 0) ? ST_WRITE : ST_DRAIN;
      ST_DRAIN: if (drain_tc) state_d = ST_WRITE;
      ST_WRITE: if (wr_tc) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (abort_hit) state_d = ST_IDLE;
  end

  // Dimensions are held internally but only exposed while busy.
  always_comb begin
    bus.start_bit_o     = (state_q == ST_FEED);
    bus.counter_o       = (state_q == ST_FEED) ? feed_cnt : '0;
    bus.reload_op_o     = (state_q == ST_CLEAR);
    bus.pe_clear_o      = (state_q == ST_CLEAR) && !bias_q;
    bus.res_we_o        = (state_q == ST_WRITE);
    bus.res_addr_o      = (state_q == ST_WRITE) ? wr_cnt : '0;
    bus.busy_o          = (state_q != ST_IDLE);
    bus.op_wr_block_o   = (state_q != ST_IDLE);
    bus.done_o          = (state_q == ST_DONE);
    bus.start_ignored_o = bus.start_i && (state_q != ST_IDLE);
    bus.k_o             = (state_q != ST_IDLE) ? k_q : '0;
    bus.m_o             = (state_q != ST_IDLE) ? m_q : '0;
    bus.n_o             = (state_q != ST_IDLE) ? n_q : '0;
  end
endmodule

// File: tb/tb_matmul_sequencer.sv
// Directed bench for matmul_sequencer: default instance (PIPE_LAT=2) and a
// PIPE_LAT=0 instance; pe_clear expectation follows MATMUL_SEQ_ACCUM_EN.
module tb_matmul_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  matmul_sequencer_if #(.CNT_W(2), .ADDR_W(1)) ifa ();
  matmul_sequencer_if #(.CNT_W(2), .ADDR_W(1)) ifb ();

  matmul_sequencer #(.BUS_WIDTH(16), .DATA_WIDTH(8), .PIPE_LAT(2)) dut_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.slave)
  );
  matmul_sequencer #(.BUS_WIDTH(16), .DATA_WIDTH(8), .PIPE_LAT(0)) dut_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.slave)
  );

  // {start_bit, counter[1:0], reload, pe_clear, res_we, res_addr, busy, done}
  logic [8:0] tab_a [12];
  logic [8:0] tab_b [9];

  function automatic logic [8:0] obs_a();
    return {ifa.start_bit_o, ifa.counter_o, ifa.reload_op_o, ifa.pe_clear_o,
            ifa.res_we_o, ifa.res_addr_o, ifa.busy_o, ifa.done_o};
  endfunction

  function automatic logic [8:0] obs_b();
    return {ifb.start_bit_o, ifb.counter_o, ifb.reload_op_o, ifb.pe_clear_o,
            ifb.res_we_o, ifb.res_addr_o, ifb.busy_o, ifb.done_o};
  endfunction

  function automatic logic [15:0] all_a();
    return {obs_a(), ifa.start_ignored_o, ifa.k_o, ifa.m_o, ifa.n_o};
  endfunction

  function automatic logic [15:0] all_b();
    return {obs_b(), ifb.start_ignored_o, ifb.k_o, ifb.m_o, ifb.n_o};
  endfunction

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [8:0] e_row;
  logic       exp_pe;

  initial begin
    tab_a[0]  = 9'b0_00_0_0_0_0_0_0;
    tab_a[1]  = 9'b0_00_1_1_0_0_1_0;
    tab_a[2]  = 9'b1_00_0_0_0_0_1_0;
    tab_a[3]  = 9'b1_01_0_0_0_0_1_0;
    tab_a[4]  = 9'b1_10_0_0_0_0_1_0;
    tab_a[5]  = 9'b1_11_0_0_0_0_1_0;
    tab_a[6]  = 9'b0_00_0_0_0_0_1_0;
    tab_a[7]  = 9'b0_00_0_0_0_0_1_0;
    tab_a[8]  = 9'b0_00_0_0_1_0_1_0;
    tab_a[9]  = 9'b0_00_0_0_1_1_1_0;
    tab_a[10] = 9'b0_00_0_0_0_0_1_1;
    tab_a[11] = 9'b0_00_0_0_0_0_0_0;
    for (int i = 0; i < 6; i++) tab_b[i] = tab_a[i];
    tab_b[6] = 9'b0_00_0_0_1_0_1_0;
    tab_b[7] = 9'b0_00_0_0_0_0_1_1;
    tab_b[8] = 9'b0_00_0_0_0_0_0_0;

    rst = 1'b1;
    ifa.start_i = 0; ifa.abort_i = 0; ifa.mode_bias_i = 0;
    ifa.dim_n_i = 0; ifa.dim_k_i = 0; ifa.dim_m_i = 0;
    ifb.start_i = 0; ifb.abort_i = 0; ifb.mode_bias_i = 0;
    ifb.dim_n_i = 0; ifb.dim_k_i = 0; ifb.dim_m_i = 0;
    repeat (2) step();
    chk("reset_a", all_a(), 16'h0);
    chk("reset_b", all_b(), 16'h0);
    rst = 1'b0;
    step();
    chk("idle_a", all_a(), 16'h0);

    // n=1, k=0, m=3 (clamps to 1): full default-latency sequence
    ifa.dim_n_i = 2'd1; ifa.dim_k_i = 2'd0; ifa.dim_m_i = 2'd3;
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    #1;
    chk("r1_c1", 16'(obs_a()), 16'(tab_a[1]));
    chk("r1_dims_kmn", {10'd0, ifa.k_o, ifa.m_o, ifa.n_o}, {10'd0, 2'd0, 2'd1, 2'd1});
    chk("r1_block", {15'd0, ifa.op_wr_block_o}, 16'd1);
    for (int c = 2; c <= 11; c++) begin
      step();
      chk($sformatf("r1_c%0d", c), 16'(obs_a()), 16'(tab_a[c]));
    end
    chk("r1_idle_all", all_a(), 16'h0);

    // PIPE_LAT=0, n=0: one WRITE cycle, done in cycle 7; k=3 m=2 clamp to 1
    ifb.dim_n_i = 2'd0; ifb.dim_k_i = 2'd3; ifb.dim_m_i = 2'd2;
    ifb.start_i = 1'b1;
    step();
    ifb.start_i = 1'b0;
    #1;
    chk("r2_c1", 16'(obs_b()), 16'(tab_b[1]));
    chk("r2_dims_kmn", {10'd0, ifb.k_o, ifb.m_o, ifb.n_o}, {10'd0, 2'd1, 2'd1, 2'd0});
    for (int c = 2; c <= 8; c++) begin
      step();
      chk($sformatf("r2_c%0d", c), 16'(obs_b()), 16'(tab_b[c]));
    end

    // start held across a FEED edge is flagged and otherwise ignored
    ifa.dim_n_i = 2'd1; ifa.dim_k_i = 2'd1; ifa.dim_m_i = 2'd1;
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    #1;
    chk("r3_c1", 16'(obs_a()), 16'(tab_a[1]));
    for (int c = 2; c <= 11; c++) begin
      step();
      if (c == 3) begin
        ifa.start_i = 1'b1;
        #1;
        chk("r3_ign_on", {15'd0, ifa.start_ignored_o}, 16'd1);
      end
      if (c == 4) begin
        chk("r3_ign_held", {15'd0, ifa.start_ignored_o}, 16'd1);
        ifa.start_i = 1'b0;
        #1;
        chk("r3_ign_off", {15'd0, ifa.start_ignored_o}, 16'd0);
      end
      chk($sformatf("r3_c%0d", c), 16'(obs_a()), 16'(tab_a[c]));
    end

    // abort in the second FEED cycle
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    #1;
    chk("r4_c1", 16'(obs_a()), 16'(tab_a[1]));
    step();
    step();
    chk("r4_c3", 16'(obs_a()), 16'(tab_a[3]));
    ifa.abort_i = 1'b1;
    step();
    ifa.abort_i = 1'b0;
    #1;
    chk("r4_abort_idle", all_a(), 16'h0);
    for (int c = 0; c < 10; c++) begin
      step();
      chk($sformatf("r4_quiet%0d", c), all_a(), 16'h0);
    end

    // asynchronous reset in DRAIN, then a complete fresh run
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    #1;
    for (int c = 2; c <= 6; c++) step();
    chk("r5_in_drain", 16'(obs_a()), 16'(tab_a[6]));
    rst = 1'b1;
    #1;
    chk("r5_async_rst", all_a(), 16'h0);
    step();
    rst = 1'b0;
    step();
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    #1;
    chk("r6_c1", 16'(obs_a()), 16'(tab_a[1]));
    for (int c = 2; c <= 11; c++) begin
      step();
      chk($sformatf("r6_c%0d", c), 16'(obs_a()), 16'(tab_a[c]));
    end

    // mode_bias_i=1: pe_clear suppressed only when accumulation is built in
`ifdef MATMUL_SEQ_ACCUM_EN
    exp_pe = 1'b0;
`else
    exp_pe = 1'b1;
`endif
    ifa.mode_bias_i = 1'b1;
    ifa.start_i = 1'b1;
    step();
    ifa.start_i = 1'b0;
    ifa.mode_bias_i = 1'b0;
    #1;
    e_row = tab_a[1];
    e_row[4] = exp_pe;
    chk("r7_c1_bias", 16'(obs_a()), 16'(e_row));
    for (int c = 2; c <= 11; c++) begin
      step();
      chk($sformatf("r7_c%0d", c), 16'(obs_a()), 16'(tab_a[c]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matmul_sequencer.md
# matmul_sequencer

Controller that sequences one matrix-multiply operation through operand register A, operand register B and the systolic PE array. On a start request it latches the operand dimensions, clears the PEs, and sweeps the shared diagonal-feed counter over all skew steps while asserting the operand-register start strobe. It then waits for the array pipeline to drain, walks the result rows into the result store, and reports completion. It sits between the APB control/status register file and the matmul datapath, and blocks operand writes while an operation is in flight.

## Interface
- BUS_WIDTH, 16, APB data width; sets MAX_DIM = BUS_WIDTH/DATA_WIDTH
- DATA_WIDTH, 8, element width
- PIPE_LAT, 2, cycles from the last feed step to a valid array output
- CNT_W (localparam), $clog2(3*MAX_DIM-2), feed counter width
- clk_i  in  1  clock; all state changes on posedge
- rst_i  in  1  asynchronous, active-high reset
- start_i  in  1  start request, level-sampled in IDLE
- abort_i  in  1  synchronous abort
- dim_n_i, dim_k_i, dim_m_i  in  2 each  operand dimensions minus one (A is n×k, B is k×m)
- mode_bias_i  in  1  accumulate onto previous result (see Configuration)
- start_bit_o  out  1  feed strobe to operand registers A and B
- counter_o  out  CNT_W  diagonal feed step
- reload_op_o  out  1  one-cycle operand reload pulse
- pe_clear_o  out  1  one-cycle PE accumulator clear
- res_we_o  out  1  result-row write enable
- res_addr_o  out  $clog2(MAX_DIM)  result row address
- op_wr_block_o  out  1  gates APB operand writes
- busy_o  out  1  operation in flight
- done_o  out  1  one-cycle completion pulse
- start_ignored_o  out  1  one-cycle pulse when a start arrives while busy
- k_o, m_o, n_o  out  2 each  latched dimensions, clamped to MAX_DIM-1

## Operation
- States: IDLE, CLEAR, FEED, DRAIN, WRITE, DONE.
- IDLE -> CLEAR when start_i=1.
  - Latch the dimensions; any value above MAX_DIM-1 is clamped to MAX_DIM-1.
- CLEAR, 1 cycle: reload_op_o=1; pe_clear_o=1. Next state is FEED with the counter at 0.
- FEED, 3*MAX_DIM-2 cycles: start_bit_o=1; counter_o counts 0 to 3*MAX_DIM-3.
  - The feed length is fixed. Zero padding outside k and m is done by the operand registers.
  - The terminal count moves to DRAIN, and the counter resets to 0.
- DRAIN, PIPE_LAT cycles: start_bit_o=0; a drain counter runs.
  - With PIPE_LAT=0, FEED goes straight to WRITE.
- WRITE, n+1 cycles: res_we_o=1; res_addr_o counts 0 to n. Rows above n are not written.
- DONE, 1 cycle: done_o=1, then IDLE.
- busy_o and op_wr_block_o are 1 in every state except IDLE.
- start_i=1 in any state other than IDLE gives start_ignored_o=1 for that cycle and has no other effect.
  - A start that arrives in the same cycle as the DONE pulse is also ignored.
- abort_i=1 in any non-IDLE state: next state is IDLE and all counters clear.
  - No done_o pulse and no further res_we_o.
  - abort_i has priority over every other transition.
- start_i held high through DONE does not retrigger. A new start is accepted only by sampling in IDLE, one cycle after DONE.

## Timing
- Reset, and any time in IDLE: every output is 0, including the latched dimensions.
- rst_i asserted mid-operation clears the state and all outputs immediately (asynchronous). Any partial result write is abandoned.
- Start sampled at edge E0:
  - CLEAR in cycle 1; FEED in cycles 2 to 3*MAX_DIM-1; DRAIN for PIPE_LAT cycles; WRITE for n+1 cycles; DONE.
  - Total start-to-done latency = 1 + (3*MAX_DIM-2) + PIPE_LAT + (n+1) + 1 cycles.
  - Defaults (MAX_DIM=2, PIPE_LAT=2) with n=1: done_o 10 cycles after E0.
- counter_o and start_bit_o are registered and change together at posedge. The operand registers sample them at the next edge.

## Configuration
- MATMUL_SEQ_ACCUM_EN defined:
  - mode_bias_i is latched at start.
  - If it is 1, pe_clear_o is suppressed in CLEAR; reload_op_o still pulses.
- Without the macro:
  - mode_bias_i is ignored.
  - pe_clear_o pulses on every operation.

## Structure
- A shared package `matmul_pkg` holds:
  - the state enum;
  - the MAX_DIM and CNT_W derivations;
  - the dimension clamp function.
- One sub-module, `seq_counter`: a loadable up-counter with terminal-count flag, instantiated for the feed, drain and write phases.
- The FSM is in the top level.

## Test plan
- Reset with all defaults: all outputs 0. Start with n=k=m=1: counter_o goes 0,1,2,3; res_addr_o goes 0,1; done_o arrives 10 cycles after start.
- n=0, PIPE_LAT=0: WRITE lasts 1 cycle (res_addr_o=0 only); done_o 7 cycles after start.
- Pulse start_i during FEED: start_ignored_o=1 for one cycle; the sequence timing is unchanged.
- abort_i at the second FEED cycle: IDLE on the next cycle; no res_we_o, no done_o; busy_o=0.
- rst_i asserted mid-DRAIN: outputs 0 immediately. A start after reset runs a full, normal sequence.
- With MATMUL_SEQ_ACCUM_EN and mode_bias_i=1: pe_clear_o stays 0 in CLEAR while reload_op_o=1. Without the macro, pe_clear_o=1.
